// File: rtl/pwm_capture_if.sv
// Measurement bundle between a PWM source/consumer and pwm_capture.
// The source drives pwm_in; the capture block returns the measured results.
interface pwm_capture_if #(
  parameter int R = 10
);
  logic        pwm_in;
  logic [31:0] period;
  logic [31:0] high_time;
  logic [R:0]  duty;
  logic        valid;
  logic        busy;
  logic        overrun;
  logic        stuck;

  modport master (
    output pwm_in,
    input  period, high_time, duty, valid, busy, overrun, stuck
  );

  modport slave (
    input  pwm_in,
    output period, high_time, duty, valid, busy, overrun, stuck
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM period/high-time capture with a serial restoring divider for duty.
// Optional stuck-input timeout is enabled by defining PWM_CAPTURE_TIMEOUT_EN.
module pwm_capture #(
  parameter int          R              = 10,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
  input logic          clk,
  input logic          reset_n,
  pwm_capture_if.slave bus
);
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_DIVIDE  = 2'd2;
  localparam int STEP_W = $clog2(R + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(R);
  localparam logic [R:0] FULL = {1'b1, {R{1'b0}}};
  localparam logic [31:0] SAT = 32'hFFFF_FFFF;

  logic              sync1_r, sync2_r, sync3_r;
  logic [1:0]        state_r;
  logic [31:0]       period_cnt_r, high_cnt_r;
  logic [31:0]       period_r, high_time_r;
  logic [R:0]        duty_r;
  logic              valid_r, busy_r, overrun_r, stuck_r;
  logic [31:0]       rem_r;
  logic [R:0]        dsr_r;
  logic [R:0]        q_r;
  logic              ovf_r;
  logic [STEP_W-1:0] step_r;

  logic        rise_s;
  logic [31:0] period_inc_s, high_inc_s;
  logic [32:0] trial_s;
  logic        ge_s;
  logic [31:0] diff_s;
  logic [R:0]  q_next_s, duty_fin_s;

  assign rise_s       = sync2_r & ~sync3_r;
  assign period_inc_s = (period_cnt_r == SAT) ? SAT : period_cnt_r + 32'd1;
  assign high_inc_s   = (sync2_r && (high_cnt_r != SAT)) ? high_cnt_r + 32'd1 : high_cnt_r;

  // One restoring step: the dividend's only nonzero low bit enters first, then zeros.
  assign trial_s    = {rem_r, dsr_r[R]};
  assign ge_s       = (trial_s >= {1'b0, period_r});
  assign diff_s     = trial_s[31:0] - period_r;
  assign q_next_s   = {q_r[R-1:0], ge_s};
  assign duty_fin_s = (ovf_r || (q_next_s > FULL)) ? FULL : q_next_s;

  assign bus.period    = period_r;
  assign bus.high_time = high_time_r;
  assign bus.duty      = duty_r;
  assign bus.valid     = valid_r;
  assign bus.busy      = busy_r;
  assign bus.overrun   = overrun_r;
  assign bus.stuck     = stuck_r;

`ifndef PWM_CAPTURE_TIMEOUT_EN
  logic unused_timeout_s;
  assign unused_timeout_s = ^TIMEOUT_CYCLES;
`endif

  // Two-flop synchronizer plus a delayed copy for rising-edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
    end else begin
      sync1_r <= bus.pwm_in;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  // Measurement counters, result registers and divider sequencing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      period_cnt_r <= 32'd0;
      high_cnt_r   <= 32'd0;
      period_r     <= 32'd0;
      high_time_r  <= 32'd0;
      duty_r       <= '0;
      valid_r      <= 1'b0;
      busy_r       <= 1'b0;
      overrun_r    <= 1'b0;
      stuck_r      <= 1'b0;
      rem_r        <= 32'd0;
      dsr_r        <= '0;
      q_r          <= '0;
      ovf_r        <= 1'b0;
      step_r       <= '0;
    end else begin
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (rise_s) begin
            period_cnt_r <= 32'd0;
            high_cnt_r   <= 32'd1;
            stuck_r      <= 1'b0;
            state_r      <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (rise_s) begin
            period_r     <= period_inc_s;
            high_time_r  <= high_cnt_r;
            // The edge cycle itself is high, so the new high count starts at one.
            period_cnt_r <= 32'd0;
            high_cnt_r   <= 32'd1;
            rem_r        <= high_cnt_r >> 1;
            dsr_r        <= {high_cnt_r[0], {R{1'b0}}};
            q_r          <= '0;
            ovf_r        <= ({1'b0, high_cnt_r} >= {period_inc_s, 1'b0});
            step_r       <= '0;
            busy_r       <= 1'b1;
            state_r      <= ST_DIVIDE;
          end
`ifdef PWM_CAPTURE_TIMEOUT_EN
          else if (period_cnt_r >= TIMEOUT_CYCLES) begin
            stuck_r <= 1'b1;
            duty_r  <= sync2_r ? FULL : '0;
            valid_r <= 1'b1;
            state_r <= ST_IDLE;
          end
`endif
          else begin
            period_cnt_r <= period_inc_s;
            high_cnt_r   <= high_inc_s;
          end
        end
        ST_DIVIDE: begin
          // An edge here drops that period; counting runs on so it merges into the next one.
          period_cnt_r <= period_inc_s;
          high_cnt_r   <= high_inc_s;
          overrun_r    <= rise_s;
          rem_r        <= ge_s ? diff_s : trial_s[31:0];
          dsr_r        <= {dsr_r[R-1:0], 1'b0};
          q_r          <= q_next_s;
          step_r       <= step_r + STEP_W'(1);
          if (step_r == LAST_STEP) begin
            duty_r  <= duty_fin_s;
            valid_r <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_MEASURE;
          end else begin
            busy_r <= 1'b1;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture (R=10, timeout 5000); covers both builds of
// PWM_CAPTURE_TIMEOUT_EN.
module tb_pwm_capture;
  localparam int R = 10;
  localparam logic [31:0] TO = 32'd5000;
  localparam logic [R:0] FULL = 11'd1024;

  typedef struct {
    logic [31:0] period;
    logic [31:0] high;
    logic [R:0]  duty;
    logic        stuck;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   overruns = 0;
  logic prev_busy = 1'b0;
  exp_t sb_q[$];

  pwm_capture_if #(.R(R)) bus ();

  pwm_capture #(.R(R), .TIMEOUT_CYCLES(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] h, input logic [R:0] d,
                      input logic st, input int c);
    exp_t e;
    e.period = p; e.high = h; e.duty = d; e.stuck = st; e.cyc = c;
    sb_q.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period"}, bus.period, 0);
    chk({tag, "_high_time"}, bus.high_time, 0);
    chk({tag, "_duty"}, bus.duty, 0);
    chk({tag, "_valid"}, bus.valid, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_overrun"}, bus.overrun, 0);
    chk({tag, "_stuck"}, bus.stuck, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk_zero("reset");
    tick(2);
    reset_n = 1'b1;
    tick(2);
  endtask

  // n+1 rising edges; edges 1..n close a full period, valid due R+4 cycles after the drive
  task automatic wave(input int p, input int h, input int n, input logic [R:0] d);
    for (int i = 0; i <= n; i++) begin
      if (i >= 1) push(p, h, d, 1'b0, cyc + R + 4);
      bus.pwm_in = 1'b1;
      tick(h);
      bus.pwm_in = 1'b0;
      tick(p - h);
    end
  endtask

  // Monitor: pop and compare on every valid pulse
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.overrun) overruns++;
      if (bus.valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("period", bus.period, e.period);
          chk("high_time", bus.high_time, e.high);
          chk("duty", bus.duty, e.duty);
          chk("stuck_at_valid", bus.stuck, e.stuck);
          if (e.cyc >= 0) chk("valid_latency", cyc, e.cyc);
          if (!e.stuck) begin
            chk("busy_before_valid", prev_busy, 1);
            chk("busy_at_valid", bus.busy, 0);
          end
        end
      end
      prev_busy = bus.busy;
    end else begin
      prev_busy = 1'b0;
    end
  end

  initial begin
    reset_n = 1'b0;
    bus.pwm_in = 1'b0;
    tick(3);
    chk_zero("por");
    reset_n = 1'b1;
    tick(2);

    // 100-cycle period, 25 high: duty 25*1024/100 = 256
    wave(100, 25, 3, 11'd256);
    do_reset();

    // 1000-cycle period, 500 high: duty 512
    wave(1000, 500, 2, 11'd512);

    // 7-cycle period, 3 high: odd edges land in DIVIDE, results span 14 cycles / 6 high -> 438
    for (int i = 0; i < 8; i++) begin
      if (i == 0) push(32'd1000, 32'd500, 11'd512, 1'b0, cyc + R + 4);
      else if (i % 2 == 0) push(32'd14, 32'd6, 11'd438, 1'b0, cyc + R + 4);
      bus.pwm_in = 1'b1;
      tick(3);
      bus.pwm_in = 1'b0;
      tick(4);
    end
    tick(30);
    chk("overrun_count", overruns, 4);
    do_reset();

    // Reset in the middle of a division: outputs drop at once, no valid follows
    bus.pwm_in = 1'b1;
    tick(5);
    bus.pwm_in = 1'b0;
    tick(95);
    bus.pwm_in = 1'b1;
    tick(5);
    bus.pwm_in = 1'b0;
    tick(3);
    chk("busy_mid_divide", bus.busy, 1);
    chk("period_mid_divide", bus.period, 100);
    reset_n = 1'b0;
    #1;
    chk_zero("async_reset");
    tick(2);
    reset_n = 1'b1;
    tick(80);
    wave(100, 25, 1, 11'd256);
    do_reset();

    // Static-high input
`ifdef PWM_CAPTURE_TIMEOUT_EN
    push(32'd0, 32'd0, FULL, 1'b1, -1);
    bus.pwm_in = 1'b1;
    tick(6000);
    chk("stuck_set", bus.stuck, 1);
    bus.pwm_in = 1'b0;
    tick(10);
    wave(100, 25, 1, 11'd256);
    chk("stuck_cleared", bus.stuck, 0);
`else
    bus.pwm_in = 1'b1;
    tick(6000);
    chk("stuck_tied_low", bus.stuck, 0);
    bus.pwm_in = 1'b0;
    tick(10);
`endif

    chk("pending_results", sb_q.size(), 0);
    chk("overrun_total", overruns, 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter R, default 10: duty resolution; duty output is R+1 bits and full scale is 2^R (100 %).
REQ-002 Parameter TIMEOUT_CYCLES, default 32'd1_000_000: cycles without a rising edge before the stuck condition is declared (used only under REQ-030).
REQ-003 clk  input  1  single clock; all state on posedge clk.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 pwm_in  input  1  asynchronous PWM waveform to measure.
REQ-006 period  output  32  clk cycles between the last two rising edges.
REQ-007 high_time  output  32  clk cycles pwm was high within that period.
REQ-008 duty  output  R+1  floor(high_time*2^R/period).
REQ-009 valid  output  1  one-cycle pulse when period, high_time and duty are all updated.
REQ-010 busy  output  1  high while the divider is running.
REQ-011 overrun  output  1  one-cycle pulse when a period is dropped.
REQ-012 stuck  output  1  level flag for a static input (see Configuration).

Function
REQ-013 pwm_in SHALL pass through a 2-FF synchronizer; edge detection SHALL use the synchronized signal and a third registered copy.
REQ-014 States SHALL be IDLE, MEASURE and DIVIDE.
REQ-015 IDLE: wait for a rising edge, then clear the counters and go to MEASURE; no valid is produced.
REQ-016 In MEASURE and DIVIDE, period_cnt SHALL increment every cycle.
REQ-017 high_cnt SHALL increment every cycle the synchronized input is 1.
REQ-018 Both counters SHALL saturate at 32'hFFFF_FFFF, with no wrap-around.
REQ-019 Rising edge in MEASURE (cycle E): latch period_cnt+1 and high_cnt into period/high_time at E+1; restart both counters at the edge; enter DIVIDE.
REQ-020 DIVIDE SHALL run a restoring divider (high_time<<R)/period for exactly R+1 cycles.
REQ-021 duty SHALL update and valid SHALL pulse at cycle E+R+2; the block then returns to MEASURE.
REQ-022 busy SHALL be 1 exactly from E+1 through E+R+1.
REQ-023 duty SHALL clamp to 2^R if the quotient exceeds 2^R.
REQ-024 period==0 cannot occur; divide-by-zero SHALL yield duty = 2^R.
REQ-025 Rising edge during DIVIDE: that period SHALL be discarded and overrun pulses.
REQ-026 After an overrun, the counters restart and the in-progress division completes normally.
REQ-027 Outputs other than valid, busy and overrun SHALL hold their values between updates.

Reset
REQ-028 reset_n low SHALL force IDLE and clear all counters and synchronizer flops.
REQ-029 reset_n low SHALL also zero period, high_time, duty, valid, busy, overrun and stuck, immediately and asynchronously, including mid-division; no valid follows an aborted division.

Configuration
REQ-030 Macro PWM_CAPTURE_TIMEOUT_EN defined: in MEASURE, if period_cnt reaches TIMEOUT_CYCLES with no rising edge:
  - stuck is set to 1;
  - duty = 2^R if the synchronized input is 1, else 0;
  - period and high_time hold their values;
  - valid pulses once;
  - the block goes to IDLE.
  stuck clears on the next rising edge.
REQ-031 Macro undefined: no timeout logic; stuck is tied to 0; counters only saturate.

Verification (R=10)
REQ-032 Period 100 clk with 25 clk high, 3 periods -> period=100, high_time=25, duty=256; valid once per period, R+2 cycles after each edge is detected.
REQ-033 Period 1000 with 500 high -> duty=512.
REQ-034 Period 7 with 3 high (edges during DIVIDE) -> overrun pulses; every valid result reports period=14 or larger, never 7.
REQ-035 Assert reset_n low for 2 cycles mid-DIVIDE -> all outputs 0 at once, no valid; the next two rising edges produce one correct result.
REQ-036 With PWM_CAPTURE_TIMEOUT_EN and TIMEOUT_CYCLES=5000, hold pwm_in high -> stuck=1, duty=1024, one valid; a resumed 25 % waveform clears stuck and yields duty=256.
REQ-037 Same stimulus as REQ-036 with the macro undefined -> stuck stays 0 and no valid is produced.
